// File: rtl/i2s_dac_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : i2s_dac_tx_if
// Description : Sample-in / I2S-out bundle for the speaker DAC serializer.
//               slave  - the serializer: takes the sample strobe, drives the
//                        status pulses and the three I2S lines.
//               master - the sample source / observer.
//   ready_in     : one-cycle strobe, sample_in valid
//   sample_in    : 16-bit two's-complement speaker sample
//   full_out     : FIFO holds FIFO_DEPTH entries
//   overflow_out : one-cycle pulse, strobed sample dropped
//   underrun_out : one-cycle pulse, frame started with FIFO empty
//   bclk_out     : I2S bit clock
//   lrclk_out    : I2S word select, 0 = left, 1 = right
//   sdata_out    : I2S serial data, MSB first
// Revision    : 1.0 - initial release
// ============================================================================
interface i2s_dac_tx_if;
  logic        ready_in;
  logic [15:0] sample_in;
  logic        full_out;
  logic        overflow_out;
  logic        underrun_out;
  logic        bclk_out;
  logic        lrclk_out;
  logic        sdata_out;

  modport slave (
    input  ready_in, sample_in,
    output full_out, overflow_out, underrun_out, bclk_out, lrclk_out, sdata_out
  );

  modport master (
    output ready_in, sample_in,
    input  full_out, overflow_out, underrun_out, bclk_out, lrclk_out, sdata_out
  );
endinterface
`default_nettype wire

// File: rtl/i2s_dac_tx.sv
`default_nettype none
// ============================================================================
// Module      : i2s_dac_tx
// Description : Speaker-side I2S transmitter. Buffers strobed 16-bit samples
//               in a small FIFO and sends each one on both I2S channels,
//               generating bclk and lrclk from the system clock.
//   clk_in : system clock, rising edge
//   rst_in : asynchronous active-low reset
//   bus    : i2s_dac_tx_if.slave (sample strobe, status pulses, I2S lines)
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_dac_tx #(
  parameter int CLK_DIV    = 32,  // system clocks per bclk half-period, >= 2
  parameter int FIFO_DEPTH = 4    // power of two, >= 2
) (
  input  wire logic    clk_in,
  input  wire logic    rst_in,
  i2s_dac_tx_if.slave  bus
);

  localparam int c_DIV_W = $clog2(CLK_DIV);
  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
  localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(FIFO_DEPTH);

  logic [c_DIV_W-1:0] r_div_cnt;
  logic               r_bclk;
  logic [4:0]         r_slot;
  logic               r_lrclk;
  logic               r_sdata;
  logic [15:0]        r_word;
  logic [15:0]        r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               r_full;
  logic               r_overflow;
  logic               r_underrun;

  logic               w_tick;
  logic               w_fall;
  logic [4:0]         w_slot_nxt;
  logic               w_load;
  logic               w_empty;
  logic               w_pop;
  logic               w_push;
  logic [15:0]        w_word_nxt;
  logic [3:0]         w_bit_idx;
  logic [c_CNT_W-1:0] w_count_nxt;

  assign w_tick     = (r_div_cnt == c_DIV_LAST);
  assign w_fall     = w_tick & r_bclk;
  assign w_slot_nxt = r_slot + 5'd1;
  // Word load happens on the fall event that enters slot 1.
  assign w_load     = w_fall & (w_slot_nxt == 5'd1);
  assign w_empty    = (r_count == '0);
  assign w_pop      = w_load & ~w_empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign w_push     = bus.ready_in & ((r_count != c_DEPTH) | w_pop);

  // The word driven from slot 1 onward; an empty FIFO sends silence.
  assign w_word_nxt = w_load ? (w_empty ? 16'h0000 : r_mem[r_rd_ptr]) : r_word;

  // One-bit-delayed I2S: slot s carries bit (16 - s) mod 16, giving
  // 15..0 for slots 1..16, 15..1 for slots 17..31 and bit 0 again in slot 0.
  assign w_bit_idx  = 4'd0 - w_slot_nxt[3:0];

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + c_CNT_W'(1);
      2'b01:   w_count_nxt = r_count - c_CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_div_cnt  <= '0;
      r_bclk     <= 1'b0;
      r_slot     <= 5'd0;
      r_lrclk    <= 1'b0;
      r_sdata    <= 1'b0;
      r_word     <= 16'h0000;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_div_cnt <= w_tick ? '0 : r_div_cnt + c_DIV_W'(1);
      if (w_tick) begin
        r_bclk <= ~r_bclk;
      end
      // lrclk and sdata move only with bclk falling, so they are stable
      // across every bclk rising edge seen by the DAC.
      if (w_fall) begin
        r_slot  <= w_slot_nxt;
        r_lrclk <= w_slot_nxt[4];
        r_sdata <= w_word_nxt[w_bit_idx];
      end
      if (w_load) begin
        r_word <= w_word_nxt;
      end
      r_underrun <= w_load & w_empty;
      r_overflow <= bus.ready_in & ~w_push;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == c_DEPTH);
    end
  end

  // Storage needs no reset: entries are only read while the count covers them.
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.sample_in;
    end
  end

  assign bus.full_out     = r_full;
  assign bus.overflow_out = r_overflow;
  assign bus.underrun_out = r_underrun;
  assign bus.bclk_out     = r_bclk;
  assign bus.lrclk_out    = r_lrclk;
  assign bus.sdata_out    = r_sdata;

endmodule
`default_nettype wire

// File: tb/tb_i2s_dac_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_dac_tx
// Description : Directed bench for i2s_dac_tx with CLK_DIV = 2, FIFO_DEPTH = 4.
//               One bclk slot is 4 clocks, one frame 128 clocks; frame f's
//               slot-1 fall event is at clock 4 + 128*f after reset release.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_dac_tx;

  localparam int c_FRAME = 128;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_err  = 0;

  i2s_dac_tx_if bus ();

  i2s_dac_tx #(
    .CLK_DIV    (2),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  // Clock edges counted since reset release.
  always @(posedge clk_in) begin
    if (!rst_in) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  function automatic int frame_start(input int f);
    return 4 + c_FRAME * f;
  endfunction

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bclk"},  16'(bus.bclk_out),     16'h0);
    chk({tag, "_lrclk"}, 16'(bus.lrclk_out),    16'h0);
    chk({tag, "_sdata"}, 16'(bus.sdata_out),    16'h0);
    chk({tag, "_full"},  16'(bus.full_out),     16'h0);
    chk({tag, "_ovf"},   16'(bus.overflow_out), 16'h0);
    chk({tag, "_udr"},   16'(bus.underrun_out), 16'h0);
  endtask

  // Walk one frame: slots 1..31 plus the next frame's slot 0 (s = 32).
  task automatic check_frame(input logic [15:0] w, input int n0, input logic ur);
    logic exp_bit;
    logic exp_lr;
    goto(n0);
    chk("fall_bclk",  16'(bus.bclk_out),     16'h0);
    chk("slot1_udr",  16'(bus.underrun_out), 16'(ur));
    chk("slot1_sdat", 16'(bus.sdata_out),    16'(w[15]));
    chk("slot1_lr",   16'(bus.lrclk_out),    16'h0);
    goto(n0 + 1);
    chk("udr_pulse",  16'(bus.underrun_out), 16'h0);
    for (int s = 2; s <= 32; s++) begin
      if (s <= 16)      exp_bit = w[16 - s];
      else if (s <= 31) exp_bit = w[32 - s];
      else              exp_bit = w[0];
      exp_lr = (s >= 16) && (s <= 31);
      goto(n0 + 4 * (s - 1) + 1);
      chk($sformatf("sdat_s%0d_w%h", s, w), 16'(bus.sdata_out), 16'(exp_bit));
      chk($sformatf("lr_s%0d", s),          16'(bus.lrclk_out), 16'(exp_lr));
    end
  endtask

  initial begin
    bus.ready_in  = 1'b0;
    bus.sample_in = 16'h0000;

    // Reset values
    repeat (3) @(negedge clk_in);
    chk_all_zero("rst");

    // Release and strobe 0x8001 into the first cycle
    rst_in        = 1'b1;
    bus.ready_in  = 1'b1;
    bus.sample_in = 16'h8001;
    goto(1);
    bus.ready_in  = 1'b0;
    chk("c1_bclk", 16'(bus.bclk_out),     16'h0);
    chk("c1_full", 16'(bus.full_out),     16'h0);
    chk("c1_ovf",  16'(bus.overflow_out), 16'h0);
    goto(2);
    chk("c2_bclk_rise", 16'(bus.bclk_out), 16'h1);
    goto(3);
    chk("c3_bclk",      16'(bus.bclk_out), 16'h1);

    // Single sample, then two underrun frames
    check_frame(16'h8001, frame_start(0), 1'b0);
    check_frame(16'h0000, frame_start(1), 1'b1);
    check_frame(16'h0000, frame_start(2), 1'b1);

    // Overflow: five back-to-back strobes during frame 3
    goto(frame_start(3));
    chk("f3_udr", 16'(bus.underrun_out), 16'h1);
    goto(frame_start(3) + 1);
    for (int i = 1; i <= 5; i++) begin
      bus.ready_in  = 1'b1;
      bus.sample_in = 16'(i);
      goto(cyc + 1);
      if (i == 3) chk("ovf_full3", 16'(bus.full_out), 16'h0);
      if (i == 4) begin
        chk("ovf_full4", 16'(bus.full_out),     16'h1);
        chk("ovf_ovf4",  16'(bus.overflow_out), 16'h0);
      end
      if (i == 5) begin
        chk("ovf_ovf5",  16'(bus.overflow_out), 16'h1);
        chk("ovf_full5", 16'(bus.full_out),     16'h1);
      end
    end
    bus.ready_in = 1'b0;
    goto(cyc + 1);
    chk("ovf_pulse", 16'(bus.overflow_out), 16'h0);

    // Full FIFO: strobe 0x1234 exactly on the slot-1 fall event of frame 4
    goto(frame_start(4) - 1);
    bus.ready_in  = 1'b1;
    bus.sample_in = 16'h1234;
    goto(frame_start(4));
    bus.ready_in  = 1'b0;
    chk("col_ovf",  16'(bus.overflow_out), 16'h0);
    chk("col_full", 16'(bus.full_out),     16'h1);

    check_frame(16'h0001, frame_start(4), 1'b0);
    check_frame(16'h0002, frame_start(5), 1'b0);
    chk("f5_full", 16'(bus.full_out), 16'h0);
    check_frame(16'h0003, frame_start(6), 1'b0);
    check_frame(16'h0004, frame_start(7), 1'b0);
    check_frame(16'h1234, frame_start(8), 1'b0);
    check_frame(16'h0000, frame_start(9), 1'b1);

    // Reset mid-frame with two samples queued
    goto(frame_start(10) + 1);
    bus.ready_in  = 1'b1;
    bus.sample_in = 16'hAAAA;
    goto(cyc + 1);
    bus.sample_in = 16'h5555;
    goto(cyc + 1);
    bus.ready_in  = 1'b0;
    chk("q2_full", 16'(bus.full_out), 16'h0);
    goto(frame_start(10) + 77);
    chk("s20_lr", 16'(bus.lrclk_out), 16'h1);
    rst_in = 1'b0;
    #1;
    chk_all_zero("midrst");
    repeat (3) @(negedge clk_in);
    chk_all_zero("midrst_hold");
    rst_in = 1'b1;
    goto(1);
    chk("post_udr",  16'(bus.underrun_out), 16'h0);
    chk("post_bclk", 16'(bus.bclk_out),     16'h0);
    check_frame(16'h0000, frame_start(0), 1'b1);
    chk("post_full", 16'(bus.full_out), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
